// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone classic arbiter.
// Round-robin grant held for the whole cyc burst, one idle cycle between
// grants, and a stall watchdog that turns an unacked access into an error.
module wb_arbiter2 #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  // master 0
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  // master 1
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  // slave
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  // current grant, one-hot
  output logic [1:0]          gnt_o
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;   // 0 = m0 granted last, 1 = m1
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                gnt0, gnt1, granted;
  logic                sel_cyc, sel_stb, sel_we;
  logic [ADDR_W-1:0]   sel_adr;
  logic [DATA_W-1:0]   sel_dat;
  logic [DATA_W/8-1:0] sel_sel;
  logic                stb_live;
  logic                to_hit;

  assign gnt0    = (state_q == ST_GNT0);
  assign gnt1    = (state_q == ST_GNT1);
  assign granted = gnt0 | gnt1;

  // Route the granted master's request; everything is zero while idle.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    if (gnt0) begin
      sel_cyc = m0_cyc_i;
      sel_stb = m0_stb_i;
      sel_we  = m0_we_i;
      sel_adr = m0_adr_i;
      sel_dat = m0_dat_i;
      sel_sel = m0_sel_i;
    end else if (gnt1) begin
      sel_cyc = m1_cyc_i;
      sel_stb = m1_stb_i;
      sel_we  = m1_we_i;
      sel_adr = m1_adr_i;
      sel_dat = m1_dat_i;
      sel_sel = m1_sel_i;
    end
  end

  // stb only counts while the cycle is open, so an abort drops both at once.
  assign stb_live = sel_cyc & sel_stb;
  // Watchdog fires only when the slave has not acked; a coincident ack wins.
  assign to_hit   = (TIMEOUT != 0) && granted && stb_live && !s_ack_i
                    && (cnt_q == TO_VAL);

  assign s_cyc_o  = sel_cyc;
  assign s_stb_o  = stb_live & ~to_hit;
  assign s_we_o   = sel_we;
  assign s_adr_o  = sel_adr;
  assign s_dat_o  = sel_dat;
  assign s_sel_o  = sel_sel;

  assign m0_ack_o = gnt0 & s_ack_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m0_err_o = gnt0 & to_hit;
  assign m1_err_o = gnt1 & to_hit;
  assign m0_dat_o = granted ? s_dat_i : '0;
  assign m1_dat_o = granted ? s_dat_i : '0;
  assign gnt_o    = {gnt1, gnt0};

  // Grant selection: round-robin on ties, held until the owner drops cyc.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
          last_d  = ~last_q;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
        end
      end
      ST_GNT0: if (!m0_cyc_i) state_d = ST_IDLE;
      ST_GNT1: if (!m1_cyc_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall counter: counts unacked strobe cycles, saturating, cleared otherwise.
  always_comb begin
    cnt_d = '0;
    if ((TIMEOUT != 0) && granted && (state_d != ST_IDLE) && stb_live
        && !s_ack_i && !to_hit) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // State, round-robin history and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: table of per-cycle vectors plus hand-built
// watchdog and reset sequences, checked through an expectation queue.
module tb_wb_arbiter2;

  localparam logic [31:0] M0_ADR = 32'h0000_0004;
  localparam logic [31:0] M0_DAT = 32'hDEAD_BEEF;
  localparam logic [3:0]  M0_SEL = 4'hF;
  localparam logic [31:0] M1_ADR = 32'h0000_0080;
  localparam logic [31:0] M1_DAT = 32'h1234_5678;
  localparam logic [3:0]  M1_SEL = 4'h3;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
  logic        m1_we_i = 1'b0;
  logic [31:0] m0_adr_i = M0_ADR, m0_dat_i = M0_DAT;
  logic [3:0]  m0_sel_i = M0_SEL;
  logic [31:0] m1_adr_i = M1_ADR, m1_dat_i = M1_DAT;
  logic [3:0]  m1_sel_i = M1_SEL;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  // Watchdog-disabled instance on the same stimulus.
  logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
  logic        z_m0_ack_o, z_m0_err_o, z_m1_ack_o, z_m1_err_o;
  logic        z_s_cyc_o, z_s_stb_o, z_s_we_o;
  logic [3:0]  z_s_sel_o;
  logic [1:0]  z_gnt_o;

  always #5 clk_i = ~clk_i;

  wb_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  wb_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_nowd (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(z_m0_dat_o), .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(z_m1_dat_o), .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o),
    .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_we_o(z_s_we_o),
    .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_sel_o(z_s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(z_gnt_o)
  );

  // in  = {rst_n, m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, s_ack}
  // out = {m0_ack, m0_err, m1_ack, m1_err, s_stb}
  typedef struct packed {
    logic [6:0]  in;
    logic [31:0] sdat;
    logic [1:0]  gnt;
    logic [4:0]  out;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s: got %h expected %h", step_no, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus after the falling edge, then compare
  // the combinational outputs before the next rising edge.
  task automatic run_step(input vec_t v);
    vec_t        e;
    logic        g0, g1;
    logic [31:0] x_adr, x_dat, x_rd;
    logic [3:0]  x_sel;
    logic        x_cyc, x_we;
    @(negedge clk_i);
    {rst_n_i, m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, s_ack_i} = v.in;
    s_dat_i = v.sdat;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    step_no++;
    g0    = e.gnt[0];
    g1    = e.gnt[1];
    x_cyc = g0 ? e.in[5] : (g1 ? e.in[2] : 1'b0);
    x_we  = g0 ? e.in[3] : 1'b0;
    x_adr = g0 ? M0_ADR : (g1 ? M1_ADR : 32'h0);
    x_dat = g0 ? M0_DAT : (g1 ? M1_DAT : 32'h0);
    x_sel = g0 ? M0_SEL : (g1 ? M1_SEL : 4'h0);
    x_rd  = (g0 | g1) ? e.sdat : 32'h0;
    chk("gnt_o",    32'(gnt_o),    32'(e.gnt));
    chk("m0_ack_o", 32'(m0_ack_o), 32'(e.out[4]));
    chk("m0_err_o", 32'(m0_err_o), 32'(e.out[3]));
    chk("m1_ack_o", 32'(m1_ack_o), 32'(e.out[2]));
    chk("m1_err_o", 32'(m1_err_o), 32'(e.out[1]));
    chk("s_stb_o",  32'(s_stb_o),  32'(e.out[0]));
    chk("s_cyc_o",  32'(s_cyc_o),  32'(x_cyc));
    chk("s_we_o",   32'(s_we_o),   32'(x_we));
    chk("s_adr_o",  s_adr_o,       x_adr);
    chk("s_dat_o",  s_dat_o,       x_dat);
    chk("s_sel_o",  32'(s_sel_o),  32'(x_sel));
    chk("m0_dat_o", m0_dat_o,      x_rd);
    chk("m1_dat_o", m1_dat_o,      x_rd);
    chk("nowd_err", 32'({z_m0_err_o, z_m1_err_o}), 32'h0);
  endtask

  initial begin
    // reset held: everything quiet
    tbl.push_back('{7'b0_000_000, 32'h0,         2'b00, 5'b00000});
    // m0 single write, ack one cycle after stb, then cyc drop
    tbl.push_back('{7'b1_111_000, 32'h0,         2'b00, 5'b00000});
    tbl.push_back('{7'b1_111_000, 32'h0,         2'b01, 5'b00001});
    tbl.push_back('{7'b1_111_001, 32'hCAFE_0001, 2'b01, 5'b10001});
    tbl.push_back('{7'b1_000_000, 32'h0,         2'b01, 5'b00000});
    tbl.push_back('{7'b1_000_000, 32'h0,         2'b00, 5'b00000});
    // reset again so the tie sequence starts from last_grant = m1
    tbl.push_back('{7'b0_000_000, 32'h0,         2'b00, 5'b00000});
    // three ties: m0, m1, m0 with an idle cycle between each
    tbl.push_back('{7'b1_110_110, 32'h0,         2'b00, 5'b00000});
    tbl.push_back('{7'b1_110_111, 32'h0000_0001, 2'b01, 5'b10001});
    tbl.push_back('{7'b1_000_110, 32'h0,         2'b01, 5'b00000});
    tbl.push_back('{7'b1_110_110, 32'h0,         2'b00, 5'b00000});
    tbl.push_back('{7'b1_110_111, 32'h0000_0002, 2'b10, 5'b00101});
    tbl.push_back('{7'b1_110_000, 32'h0,         2'b10, 5'b00000});
    tbl.push_back('{7'b1_110_110, 32'h0,         2'b00, 5'b00000});
    tbl.push_back('{7'b1_110_111, 32'h0000_0003, 2'b01, 5'b10001});
    tbl.push_back('{7'b1_000_000, 32'h0,         2'b01, 5'b00000});
    tbl.push_back('{7'b1_000_000, 32'h0,         2'b00, 5'b00000});
    // m1 4-beat read burst while m0 waits
    tbl.push_back('{7'b1_000_110, 32'h0,         2'b00, 5'b00000});
    tbl.push_back('{7'b1_110_111, 32'h0000_0011, 2'b10, 5'b00101});
    tbl.push_back('{7'b1_110_111, 32'h0000_0022, 2'b10, 5'b00101});
    tbl.push_back('{7'b1_110_111, 32'h0000_0033, 2'b10, 5'b00101});
    tbl.push_back('{7'b1_110_111, 32'h0000_0044, 2'b10, 5'b00101});
    tbl.push_back('{7'b1_110_000, 32'h0,         2'b10, 5'b00000});
    tbl.push_back('{7'b1_110_000, 32'h0,         2'b00, 5'b00000});
    tbl.push_back('{7'b1_110_001, 32'h0000_0055, 2'b01, 5'b10001});
    tbl.push_back('{7'b1_000_000, 32'h0,         2'b01, 5'b00000});
    tbl.push_back('{7'b1_000_000, 32'h0,         2'b00, 5'b00000});

    foreach (tbl[i]) run_step(tbl[i]);

    // watchdog: m0 read never acked -> err on the 9th stb cycle only
    run_step('{7'b1_110_000, 32'h0, 2'b00, 5'b00000});
    for (int k = 1; k <= 8; k++)
      run_step('{7'b1_110_000, 32'h0, 2'b01, 5'b00001});
    run_step('{7'b1_110_000, 32'h0, 2'b01, 5'b01000});
    run_step('{7'b1_110_000, 32'h0, 2'b01, 5'b00001});
    run_step('{7'b1_000_000, 32'h0, 2'b01, 5'b00000});
    run_step('{7'b1_000_000, 32'h0, 2'b00, 5'b00000});

    // ack lands exactly when the counter reaches the limit: ack wins
    run_step('{7'b1_110_000, 32'h0, 2'b00, 5'b00000});
    for (int k = 1; k <= 8; k++)
      run_step('{7'b1_110_000, 32'h0, 2'b01, 5'b00001});
    run_step('{7'b1_110_001, 32'h0000_0077, 2'b01, 5'b10001});
    run_step('{7'b1_000_000, 32'h0, 2'b01, 5'b00000});
    run_step('{7'b1_000_000, 32'h0, 2'b00, 5'b00000});

    // asynchronous reset in the middle of an m1 grant, then a tie
    run_step('{7'b1_000_110, 32'h0,         2'b00, 5'b00000});
    run_step('{7'b1_000_110, 32'h0,         2'b10, 5'b00001});
    run_step('{7'b0_000_111, 32'h0000_0099, 2'b00, 5'b00000});
    run_step('{7'b1_110_110, 32'h0,         2'b00, 5'b00000});
    run_step('{7'b1_110_111, 32'h0000_00AA, 2'b01, 5'b10001});
    run_step('{7'b1_000_000, 32'h0,         2'b01, 5'b00000});
    run_step('{7'b1_000_000, 32'h0,         2'b00, 5'b00000});

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
